data_sram_ctrl: RTL
===================

# data_sram_ctrl

Data-memory controller directly downstream of the MEM stage. It accepts the MEM stage's word-access request (ce/we/addr/sel/data), runs a multi-cycle access on an external asynchronous 32-bit SRAM, and stalls the pipeline until the access completes. It returns load data to MEM in the cycle the stall drops.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width. The byte address maps as `mem_addr_i[ADDR_W+1:2]`.
- `WAIT_CYCLES`, 2: number of cycles SRAM strobes are held per access. Legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **asynchronous, active-low** reset.
- `mem_ce_i` in 1: access request from MEM.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_addr_i` in 32: byte address.
- `mem_sel_i` in 4: byte enables, active-high.
- `mem_data_i` in 32: store data.
- `mem_data_o` out 32: load data returned to MEM.
- `stall_req_o` out 1: holds the pipeline while high.
- `err_o` out 1: one-cycle pulse when an access is dropped by the address check.
- `sram_addr_o` out ADDR_W: SRAM word address.
- `sram_wdata_o` out 32: SRAM write data.
- `sram_wdata_oe_o` out 1: data-bus drive enable for the top-level tristate.
- `sram_rdata_i` in 32: SRAM read data.
- `sram_ce_n_o` out 1: SRAM chip enable, active-low.
- `sram_oe_n_o` out 1: SRAM output enable, active-low.
- `sram_we_n_o` out 1: SRAM write enable, active-low.
- `sram_be_n_o` out 4: SRAM byte enables, active-low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If `mem_ce_i` is high and `mem_sel_i` is not 0000: latch addr, we, sel and data, load the wait counter with WAIT_CYCLES-1, and go to ACCESS. `stall_req_o` is high in this cycle.
  - If `mem_ce_i` is high and `mem_sel_i` is 0000 (misaligned access, as MEM reports it): no access, no stall, `mem_data_o` = 0, stay in IDLE.
- **ACCESS**
  - `sram_ce_n_o` = 0 and `sram_be_n_o` = ~latched sel.
  - Store: `sram_we_n_o` = 0, `sram_wdata_oe_o` = 1.
  - Load: `sram_oe_n_o` = 0.
  - `stall_req_o` = 1.
  - The counter decrements each cycle. When it reaches 0, capture `sram_rdata_i` into the read-data register (loads only) and go to DONE.
- **DONE**
  - All strobes inactive, `stall_req_o` = 0, `mem_data_o` = captured data (0 for stores).
  - Unconditional transition to IDLE.
  - `mem_ce_i` in DONE belongs to the completing instruction and is ignored.
- `stall_req_o` is combinational: `(IDLE && mem_ce_i && sel != 0) || ACCESS`.
- `sram_addr_o` and `sram_wdata_o` are driven from the latched registers at all times.
- Address bits above `ADDR_W+1` are ignored (aliasing) unless the address check is compiled in.

## Timing
- Reset values: state IDLE, counter 0, all latches 0. `mem_data_o` = 0, `stall_req_o` = 0, `err_o` = 0, `sram_addr_o` = 0, `sram_wdata_o` = 0, `sram_wdata_oe_o` = 0. `sram_ce_n_o`, `sram_oe_n_o` and `sram_we_n_o` = 1; `sram_be_n_o` = 1111.
- Stall length is exactly 1 + WAIT_CYCLES cycles; the load result is visible in the DONE cycle.
- Back-to-back accesses: the next request is accepted in the IDLE cycle that follows DONE, so there is a minimum 1-cycle gap with strobes deasserted between accesses.
- Reset asserted mid-ACCESS: strobes deassert immediately (asynchronous), the access is lost, and `stall_req_o` drops.
- Strobes come from registered state only; there are no combinational paths from `mem_*_i` to the `sram_*` pins.

## Configuration
- `DSRAM_ADDR_CHECK_EN` defined:
  - An IDLE request with `mem_addr_i[31:ADDR_W+2]` ≠ 0 performs no access and no stall.
  - `mem_data_o` = 0 and `err_o` pulses high for that cycle.
- `DSRAM_ADDR_CHECK_EN` undefined: `err_o` is tied to 0 and upper address bits alias.

## Structure
- The shared `header.v` holds the FSM state encodings (`DSRAM_IDLE`, `DSRAM_ACCESS`, `DSRAM_DONE`) and the default WAIT_CYCLES; these reuse the existing `zeroWord`, `ChipEnable` and `WriteEnable` defines.
- One sub-module, `dsram_wait_cnt`: a loadable 4-bit down-counter with a `zero` flag, instantiated once.

## Test plan
- **Store.** WAIT_CYCLES = 2; store addr 0x0000_0010, data 0xDEADBEEF, sel 1111.
  - `stall_req_o` is high for 3 cycles.
  - `sram_addr_o` = 0x00004, `sram_we_n_o` low for 2 cycles, `sram_be_n_o` = 0000.
- **Load.** Load from 0x0000_0010 with the SRAM model returning 0xDEADBEEF.
  - `mem_data_o` = 0xDEADBEEF in the DONE cycle, where `stall_req_o` = 0.
- **Misaligned.** `mem_ce_i` = 1, sel 0000, addr 0x0000_0013.
  - No stall, `sram_ce_n_o` stays 1, `mem_data_o` = 0.
- **Reset mid-access.** Assert `rst` low in the 2nd ACCESS cycle of a store.
  - All outputs return to reset values without waiting for a clock edge; state is IDLE after release.
- **Back-to-back.** Load 0x20 then store 0x24 (data 0x12345678, sel 0011).
  - The second access starts in the IDLE cycle after DONE.
  - `sram_be_n_o` = 1100 during the second ACCESS.
- **Address check.** With `DSRAM_ADDR_CHECK_EN` defined and ADDR_W = 20, load from 0x0100_0000.
  - `err_o` pulses for 1 cycle, no stall, no SRAM strobes.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// Shared types for the data SRAM controller: FSM state encoding, wait-counter
// width and the default strobe length.
package data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } dsram_state_e;

  localparam int unsigned DsramCntW           = 4;
  localparam int unsigned DsramWaitCyclesDflt = 2;

  // Preload that keeps the strobes asserted for exactly wait_cycles cycles.
  function automatic logic [DsramCntW-1:0] dsram_wait_load(input int unsigned wait_cycles);
    return DsramCntW'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/data_sram_ctrl_wait_cnt.sv
// Loadable down-counter that times the SRAM strobe window; zero_o marks the
// last strobe cycle.
module dsram_wait_cnt
  import data_sram_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DsramCntW-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [DsramCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DsramCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_sram_ctrl.sv
// Data-memory controller: turns MEM-stage word requests into timed accesses on
// an asynchronous SRAM and stalls the pipeline meanwhile. Optional upper-address
// range check is compiled in with DSRAM_ADDR_CHECK_EN.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = DsramWaitCyclesDflt
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic              sram_wdata_oe_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam logic [DsramCntW-1:0] WaitLoad = dsram_wait_load(WAIT_CYCLES);

  dsram_state_e      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ce_n_q, oe_n_q, we_n_q, wdata_oe_q;
  logic [3:0]        be_n_q;

  logic addr_bad;
  logic accept;
  logic cnt_zero;

  // Byte-lane bits never reach the SRAM; upper bits only matter to the range check.
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef DSRAM_ADDR_CHECK_EN
  assign addr_bad = (mem_addr_i >> (ADDR_W + 2)) != '0;
  assign err_o    = (state_q == StIdle) && mem_ce_i && addr_bad;
`else
  assign addr_bad = 1'b0;
  assign err_o    = 1'b0;
`endif

  assign accept = (state_q == StIdle) && mem_ce_i && (mem_sel_i != 4'b0000) && !addr_bad;

  dsram_wait_cnt u_wait_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (accept),
    .load_val_i (WaitLoad),
    .dec_i      (state_q == StAccess),
    .zero_o     (cnt_zero)
  );

  // Strobes are registered so the SRAM pins never see a path from mem_*_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      wdata_oe_q <= 1'b0;
      be_n_q     <= 4'b1111;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StAccess;
            addr_q     <= mem_addr_i[ADDR_W+1:2];
            we_q       <= mem_we_i;
            wdata_q    <= mem_data_i;
            rdata_q    <= '0;
            ce_n_q     <= 1'b0;
            oe_n_q     <= mem_we_i;
            we_n_q     <= ~mem_we_i;
            wdata_oe_q <= mem_we_i;
            be_n_q     <= ~mem_sel_i;
          end
        end
        StAccess: begin
          if (cnt_zero) begin
            state_q    <= StDone;
            if (!we_q) begin
              rdata_q <= sram_rdata_i;
            end
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            wdata_oe_q <= 1'b0;
            be_n_q     <= 4'b1111;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stall_req_o     = accept || (state_q == StAccess);
  assign mem_data_o      = (state_q == StDone) ? rdata_q : '0;
  assign sram_addr_o     = addr_q;
  assign sram_wdata_o    = wdata_q;
  assign sram_wdata_oe_o = wdata_oe_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_be_n_o     = be_n_q;

endmodule
